// File: rtl/call_stack_pkg.sv
// Shared sizing for the Fibonacci call stack, its datapath and controller.
// Contents:
//   DefWidth / DefDepth   default word width and number of entries
//   cnt_width()           occupancy width able to hold 0..depth
//   addr_width()          register-file index width
//   stack_op_e            decoded push/pop combination
package call_stack_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDepth = 16;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef enum logic [1:0] {
    OpIdle    = 2'b00,
    OpPop     = 2'b01,
    OpPush    = 2'b10,
    OpReplace = 2'b11
  } stack_op_e;

endpackage

// File: rtl/call_stack_if.sv
// Bus between the datapath (master) and the call stack (slave).
// Signals:
//   clr, push, pop, din                     master -> stack
//   dout, count, empty, full,               stack -> master
//   overflow, underflow, high_water
interface call_stack_if
  import call_stack_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned CNT_W = cnt_width(DEPTH)
);

  logic             clr;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;
  logic [CNT_W-1:0] high_water;

  modport master (
    output clr, push, pop, din,
    input  dout, count, empty, full, overflow, underflow, high_water
  );

  modport slave (
    input  clr, push, pop, din,
    output dout, count, empty, full, overflow, underflow, high_water
  );

endinterface

// File: rtl/call_stack_regfile.sv
// DEPTH x WIDTH storage for the call stack: one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write index
//   wdata_i  write data
//   raddr_i  read index
//   rdata_o  read data (combinational)
module call_stack_regfile
  import call_stack_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  localparam int unsigned AW   = addr_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/call_stack.sv
// LIFO of spilled recursion frames (flag, n, partial result) for the
// recursive-Fibonacci datapath, with occupancy, full/empty, high-water and
// sticky overflow/underflow status.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    call_stack_if slave: clr/push/pop/din in; dout/count/empty/full/
//          overflow/underflow/high_water out
module call_stack
  import call_stack_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  localparam int unsigned CNT_W = cnt_width(DEPTH),
  localparam int unsigned AW    = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  call_stack_if.slave   bus
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] hw_q, hw_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             is_empty, is_full;
  logic [CNT_W-1:0] top_idx;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] rdata;
  stack_op_e        op;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));
  // Only meaningful when not empty; wraps harmlessly otherwise.
  assign top_idx  = count_q - CNT_W'(1);
  assign op       = stack_op_e'({bus.push, bus.pop});

  always_comb begin
    count_d = count_q;
    hw_d    = hw_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we      = 1'b0;
    waddr   = count_q[AW-1:0];

    if (bus.clr) begin
      count_d = '0;
      hw_d    = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      unique case (op)
        OpPush: begin
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            we      = 1'b1;
            count_d = count_q + CNT_W'(1);
          end
        end
        OpPop: begin
          if (is_empty) begin
            unf_d = 1'b1;
          end else begin
            count_d = top_idx;
          end
        end
        OpReplace: begin
          we = 1'b1;
          if (is_empty) begin
            // Nothing to replace: acts as a push into slot 0, still flagged.
            unf_d   = 1'b1;
            count_d = CNT_W'(1);
          end else begin
            waddr = top_idx[AW-1:0];
          end
        end
        default: ;
      endcase
      if (count_d > hw_q) begin
        hw_d = count_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      hw_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      hw_q    <= hw_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  call_stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk_i   (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (bus.din),
    .raddr_i (top_idx[AW-1:0]),
    .rdata_o (rdata)
  );

  assign bus.dout       = is_empty ? '0 : rdata;
  assign bus.count      = count_q;
  assign bus.empty      = is_empty;
  assign bus.full       = is_full;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = unf_q;
  assign bus.high_water = hw_q;

endmodule

// File: tb/tb_call_stack.sv
// Directed self-checking bench for call_stack (WIDTH=8, DEPTH=16).
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_call_stack;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  call_stack_if #(.WIDTH(8), .DEPTH(16)) bus ();

  call_stack #(
    .WIDTH (8),
    .DEPTH (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clr  = 1'b0;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.din  = 8'h00;
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d);
    bus.push = 1'b1;
    bus.din  = d;
    tick();
    bus.push = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_cnt: count=%0d empty=%b full=%b, want 0/1/0",
               bus.count, bus.empty, bus.full);
    end
    vectors++;
    if (bus.dout !== 8'h00 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0 ||
        bus.high_water !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_stat: dout=%h ovf=%b unf=%b hw=%0d, want 00/0/0/0",
               bus.dout, bus.overflow, bus.underflow, bus.high_water);
    end
  endtask

  task automatic test_push_pop();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h01;
    exp_d[1] = 8'h03;
    exp_d[2] = 8'h05;
    push_byte(8'h05);
    push_byte(8'h03);
    push_byte(8'h01);
    vectors++;
    if (bus.count !== 5'd3 || bus.high_water !== 5'd3) begin
      miscompares++;
      $display("FAIL pp_fill: count=%0d hw=%0d, want 3/3", bus.count, bus.high_water);
    end
    bus.pop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus.dout !== exp_d[i]) begin
        miscompares++;
        $display("FAIL pp_dout%0d: dout=%h, want %h", i, bus.dout, exp_d[i]);
      end
      tick();
    end
    bus.pop = 1'b0;
    vectors++;
    if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.high_water !== 5'd3 ||
        bus.dout !== 8'h00 || bus.underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL pp_end: count=%0d empty=%b hw=%0d dout=%h unf=%b, want 0/1/3/00/0",
               bus.count, bus.empty, bus.high_water, bus.dout, bus.underflow);
    end
  endtask

  task automatic test_full();
    do_clr();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    vectors++;
    if (bus.full !== 1'b1 || bus.count !== 5'd16 || bus.overflow !== 1'b0 ||
        bus.dout !== 8'h0F) begin
      miscompares++;
      $display("FAIL full_fill: full=%b count=%0d ovf=%b dout=%h, want 1/16/0/0f",
               bus.full, bus.count, bus.overflow, bus.dout);
    end
    push_byte(8'hAA);
    vectors++;
    if (bus.overflow !== 1'b1 || bus.count !== 5'd16 || bus.dout !== 8'h0F) begin
      miscompares++;
      $display("FAIL full_ovf: ovf=%b count=%0d dout=%h, want 1/16/0f",
               bus.overflow, bus.count, bus.dout);
    end
    bus.push = 1'b1;
    bus.pop  = 1'b1;
    bus.din  = 8'h77;
    tick();
    idle_inputs();
    vectors++;
    if (bus.dout !== 8'h77 || bus.count !== 5'd16 || bus.underflow !== 1'b0 ||
        bus.high_water !== 5'd16 || bus.overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL full_repl: dout=%h count=%0d unf=%b hw=%0d ovf=%b, want 77/16/0/16/1",
               bus.dout, bus.count, bus.underflow, bus.high_water, bus.overflow);
    end
    // Entry below the top must survive the replace.
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    vectors++;
    if (bus.dout !== 8'h0E || bus.count !== 5'd15 || bus.full !== 1'b0) begin
      miscompares++;
      $display("FAIL full_pop: dout=%h count=%0d full=%b, want 0e/15/0",
               bus.dout, bus.count, bus.full);
    end
  endtask

  task automatic test_underflow();
    do_clr();
    vectors++;
    if (bus.overflow !== 1'b0 || bus.high_water !== 5'd0 || bus.count !== 5'd0) begin
      miscompares++;
      $display("FAIL clr_first: ovf=%b hw=%0d count=%0d, want 0/0/0",
               bus.overflow, bus.high_water, bus.count);
    end
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    vectors++;
    if (bus.underflow !== 1'b1 || bus.count !== 5'd0 || bus.empty !== 1'b1) begin
      miscompares++;
      $display("FAIL unf_pop: unf=%b count=%0d empty=%b, want 1/0/1",
               bus.underflow, bus.count, bus.empty);
    end
    bus.push = 1'b1;
    bus.pop  = 1'b1;
    bus.din  = 8'h42;
    tick();
    idle_inputs();
    vectors++;
    if (bus.count !== 5'd1 || bus.dout !== 8'h42 || bus.underflow !== 1'b1 ||
        bus.high_water !== 5'd1) begin
      miscompares++;
      $display("FAIL unf_repl: count=%0d dout=%h unf=%b hw=%0d, want 1/42/1/1",
               bus.count, bus.dout, bus.underflow, bus.high_water);
    end
    // clr wins over a simultaneous push.
    bus.push = 1'b1;
    bus.din  = 8'h99;
    do_clr();
    bus.push = 1'b0;
    vectors++;
    if (bus.count !== 5'd0 || bus.underflow !== 1'b0 || bus.high_water !== 5'd0 ||
        bus.dout !== 8'h00) begin
      miscompares++;
      $display("FAIL unf_clr: count=%0d unf=%b hw=%0d dout=%h, want 0/0/0/00",
               bus.count, bus.underflow, bus.high_water, bus.dout);
    end
  endtask

  task automatic test_async_reset();
    push_byte(8'h11);
    push_byte(8'h22);
    vectors++;
    if (bus.count !== 5'd2 || bus.dout !== 8'h22) begin
      miscompares++;
      $display("FAIL ar_pre: count=%0d dout=%h, want 2/22", bus.count, bus.dout);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.count !== 5'd0 || bus.dout !== 8'h00 || bus.empty !== 1'b1 ||
        bus.high_water !== 5'd0) begin
      miscompares++;
      $display("FAIL ar_async: count=%0d dout=%h empty=%b hw=%0d, want 0/00/1/0",
               bus.count, bus.dout, bus.empty, bus.high_water);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    push_byte(8'h33);
    vectors++;
    if (bus.dout !== 8'h33 || bus.count !== 5'd1) begin
      miscompares++;
      $display("FAIL ar_post: dout=%h count=%0d, want 33/1", bus.dout, bus.count);
    end
  endtask

  task automatic test_fib_frame();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'd2;
    exp_d[1] = 8'd4;
    exp_d[2] = 8'd1;
    do_clr();
    push_byte(8'd1);
    push_byte(8'd4);
    push_byte(8'd2);
    vectors++;
    if (bus.high_water !== 5'd3) begin
      miscompares++;
      $display("FAIL fib_hw: hw=%0d, want 3", bus.high_water);
    end
    bus.pop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus.dout !== exp_d[i]) begin
        miscompares++;
        $display("FAIL fib_dout%0d: dout=%h, want %h", i, bus.dout, exp_d[i]);
      end
      tick();
    end
    bus.pop = 1'b0;
    vectors++;
    if (bus.empty !== 1'b1 || bus.high_water !== 5'd3 || bus.underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL fib_end: empty=%b hw=%0d unf=%b, want 1/3/0",
               bus.empty, bus.high_water, bus.underflow);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    idle_inputs();
    test_reset();
    test_push_pop();
    test_full();
    test_underflow();
    test_async_reset();
    test_fib_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
- LIFO storage for the recursive-Fibonacci datapath; holds spilled frames: flag, argument n and partial result.
- Directly downstream of the datapath's stack-input mux. Consumes din/push/pop; produces dout, which the datapath loads into its n, flag and result registers.
- Adds occupancy, full/empty and sticky error status so the controller and bench can detect recursion-depth violations.

Parameters:
WIDTH, 8, data word width (matches datapath 8-bit registers)
DEPTH, 16, number of entries; maximum recursion frames x words per frame
CNT_W, $clog2(DEPTH+1), width of occupancy and high-water outputs

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
clr  input  1  synchronous clear of stack contents and status
push  input  1  write din onto top at clock edge
pop  input  1  remove top entry at clock edge
din  input  WIDTH  data to push
dout  output  WIDTH  current top-of-stack, combinational from state
count  output  CNT_W  current occupancy 0..DEPTH
empty  output  1  count == 0
full  output  1  count == DEPTH
overflow  output  1  sticky: a push was dropped
underflow  output  1  sticky: a pop was attempted while empty
high_water  output  CNT_W  maximum count reached since reset or clr

Behaviour:
- Reset (rst_n low, async): count=0, empty=1, full=0, overflow=0, underflow=0, high_water=0, dout=0. Memory array is not reset.
- dout = mem[count-1] when !empty, else 0. Read is zero-latency: the datapath samples dout and asserts pop in the same cycle; the entry is removed at that edge.
- Priority order per edge: rst_n, then clr, then push/pop.
- clr: count=0, overflow=0, underflow=0, high_water=0. push/pop ignored that cycle.
- push only, !full: mem[count]=din; count+1.
- push only, full: write dropped; count unchanged; overflow set.
- pop only, !empty: count-1. Memory is unchanged.
- pop only, empty: no change to count; underflow set.
- push & pop, !empty: top replaced. mem[count-1]=din; count unchanged. No error, including when full.
- push & pop, empty: behaves as push (count becomes 1, mem[0]=din); underflow set.
- high_water: updated to the next count when the next count > high_water. Saturates at DEPTH.
- Sticky flags clear only on rst_n or clr.
- No wrap-around: count never exceeds DEPTH and never goes below 0.
- Reset asserted mid-sequence: all outputs return to reset values immediately (async). The first push after release lands at mem[0].
- All outputs other than dout are registered or decoded directly from registered count. No combinational path from push/pop to any output.

Decomposition:
- Shared package: default WIDTH/DEPTH constants and the CNT_W derivation. The datapath and controller size against the same values.
- One sub-module, stack_regfile: DEPTH x WIDTH array with single write port (we, waddr, wdata) and one async read port. Not reset.
- Pointer/status logic lives in call_stack.

Test Plan:
- Reset then idle -> count=0, empty=1, full=0, dout=0x00, overflow=underflow=0, high_water=0.
- Push 0x05, 0x03, 0x01 on consecutive cycles, then pop x3 -> dout reads 0x01, 0x03, 0x05 before each pop edge. count 3->0, high_water=3, empty=1 at end.
- Push 0x00..0x0F (16 pushes) then push 0xAA -> full=1, count=16, overflow=1, dout=0x0F. Then push&pop with 0x77 -> dout=0x77, count=16, no new error.
- From empty, pop -> underflow=1, count=0. Then push&pop with 0x42 -> count=1, dout=0x42, underflow still 1. Then clr -> count=0, underflow=0, high_water=0.
- Push 0x11, 0x22, drop rst_n low between clock edges -> count=0, dout=0 immediately. After release, push 0x33 -> dout=0x33, count=1.
- Fibonacci-frame pattern: push flag=1, n=4, res=2; pop x3 with ns/fs/ress-style sampling -> values 2, 4, 1 returned in order. high_water=3.
